// File: rtl/fast_path_pkg.sv
// -----------------------------------------------------------------------------
// fast_path_pkg
// Shared types and constants for the fast_path_pipe block.
//   fp_mode_t : per-beat transform mode carried with each beat
//   FP_CNT_W  : width of the completed-transfer counter
// -----------------------------------------------------------------------------
package fast_path_pkg;

  typedef enum logic [1:0] {
    FP_PASS0 = 2'd0,
    FP_PASS1 = 2'd1,
    FP_INV   = 2'd2,
    FP_ROT   = 2'd3
  } fp_mode_t;

  localparam int FP_CNT_W = 16;

endpackage : fast_path_pkg

// File: rtl/fpp_stage.sv
// -----------------------------------------------------------------------------
// fpp_stage
// One pipeline stage: a W-bit data register plus its valid bit.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   up_valid    : upstream holds a beat for this stage
//   d           : data presented by upstream
//   down_ready  : downstream stage is empty or advancing (or out_ready)
//   q           : registered data, only changes on a load
//   valid       : this stage holds a beat
//   ready       : this stage can take a beat this cycle
// -----------------------------------------------------------------------------
module fpp_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] d,
  input  logic         down_ready,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         ready
);

  // A stage can load when it is empty or its current beat leaves this cycle.
  assign ready = !valid || down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (up_valid && ready) begin
        q     <= d;
        valid <= 1'b1;
      end else if (down_ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule : fpp_stage

// File: rtl/fast_path_pipe.sv
// -----------------------------------------------------------------------------
// fast_path_pipe
// Selects one of NUM_CH input channels, applies a per-beat transform in
// stage 2 and passes the result through a DEPTH-stage valid/ready pipeline.
// Parameters: WIDTH (data width), NUM_CH (>=2), DEPTH (>=2, also latency),
//             ROT (rotate-right amount for mode 3, 0 < ROT < WIDTH).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data             : channel k at [k*WIDTH +: WIDTH]
//   in_sel              : channel select; out-of-range takes channel 0
//   in_mode             : transform mode captured with the beat
//   out_valid/out_ready : output handshake
//   out_data            : transformed data, stable while stalled
//   xfer_cnt            : completed output handshakes, wraps
//   sel_err             : sticky, an out-of-range in_sel was accepted
//   out_parity          : XOR of out_data, registered with it; present only
//                         when FAST_PATH_PIPE_PARITY_EN is defined
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid never waits on ready; in_ready is combinational from
// out_ready through the stage valid chain (no skid buffer), so in_ready is
// high whenever out_ready is high or any stage is empty.
// -----------------------------------------------------------------------------
module fast_path_pipe
  import fast_path_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 3,
  parameter int ROT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  input  logic [$clog2(NUM_CH)-1:0] in_sel,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [FP_CNT_W-1:0]       xfer_cnt,
  output logic                      sel_err
`ifdef FAST_PATH_PIPE_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  localparam int SEL_W = $clog2(NUM_CH);

  function automatic logic [WIDTH-1:0] fp_xform(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       m);
    case (fp_mode_t'(m))
      FP_INV:  return ~d;
      FP_ROT:  return (d >> ROT) | (d << (WIDTH - ROT));
      default: return d;
    endcase
  endfunction

  // Channel select; anything that matches no channel falls back to channel 0.
  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;

  always_comb begin
    sel_data = in_data[WIDTH-1:0];
    sel_oob  = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_oob  = 1'b0;
      end
    end
  end

  // Stage interconnect. stg_rdy[k] is stage k's ready; the slot past the
  // last stage is the downstream out_ready.
  logic [WIDTH-1:0] stg_q [DEPTH];
  logic [DEPTH-1:0] stg_v;
  logic [DEPTH:0]   stg_rdy;
  logic [1:0]       mode_q;

  assign stg_rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      // Stage 1 carries the mode bits alongside the selected channel.
      logic [WIDTH+1:0] q_w;
      fpp_stage #(.W(WIDTH + 2)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (in_valid),
        .d          ({in_mode, sel_data}),
        .down_ready (stg_rdy[1]),
        .q          (q_w),
        .valid      (stg_v[0]),
        .ready      (stg_rdy[0])
      );
      assign mode_q   = q_w[WIDTH+1:WIDTH];
      assign stg_q[0] = q_w[WIDTH-1:0];
    end else begin : g_rest
      // Stage 2 applies the transform at its input; later stages just delay.
      logic [WIDTH-1:0] d_in;
      assign d_in = (i == 1) ? fp_xform(stg_q[0], mode_q) : stg_q[i-1];
      if (i == DEPTH - 1) begin : g_last
`ifdef FAST_PATH_PIPE_PARITY_EN
        logic [WIDTH:0] q_w;
        fpp_stage #(.W(WIDTH + 1)) u_stage (
          .clk        (clk),
          .rst        (rst),
          .up_valid   (stg_v[i-1]),
          .d          ({^d_in, d_in}),
          .down_ready (stg_rdy[i+1]),
          .q          (q_w),
          .valid      (stg_v[i]),
          .ready      (stg_rdy[i])
        );
        assign out_parity = q_w[WIDTH];
        assign stg_q[i]   = q_w[WIDTH-1:0];
`else
        fpp_stage #(.W(WIDTH)) u_stage (
          .clk        (clk),
          .rst        (rst),
          .up_valid   (stg_v[i-1]),
          .d          (d_in),
          .down_ready (stg_rdy[i+1]),
          .q          (stg_q[i]),
          .valid      (stg_v[i]),
          .ready      (stg_rdy[i])
        );
`endif
      end else begin : g_mid
        fpp_stage #(.W(WIDTH)) u_stage (
          .clk        (clk),
          .rst        (rst),
          .up_valid   (stg_v[i-1]),
          .d          (d_in),
          .down_ready (stg_rdy[i+1]),
          .q          (stg_q[i]),
          .valid      (stg_v[i]),
          .ready      (stg_rdy[i])
        );
      end
    end
  end

  assign in_ready  = stg_rdy[0];
  assign out_valid = stg_v[DEPTH-1];
  assign out_data  = stg_q[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 1'b1;
      if (in_valid && in_ready && sel_oob) sel_err <= 1'b1;
    end
  end

endmodule : fast_path_pipe
